// File: rtl/systolic_drain_if.sv
// Result-drain bus between the systolic array bottom row, the drain block and the row consumer.
// The slave modport is the drain block's view; the master modport is the driver and consumer side.
interface systolic_drain_if #(
    parameter int COLS  = 4,
    parameter int DEPTH = 4
);
    logic [COLS*8-1:0]       y_col;
    logic                    y_vld;
    logic [COLS*8-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    clr_ovf;
    logic                    ovf;
    logic [7:0]              row_cnt;
    logic [$clog2(DEPTH):0]  fifo_cnt;

    modport master (
        output y_col, y_vld, out_ready, clr_ovf,
        input  out_data, out_valid, ovf, row_cnt, fifo_cnt
    );

    modport slave (
        input  y_col, y_vld, out_ready, clr_ovf,
        output out_data, out_valid, ovf, row_cnt, fifo_cnt
    );
endinterface

// File: rtl/systolic_drain.sv
// Deskews the staggered bottom-row outputs of a systolic array into whole rows
// and queues them in a small FIFO for a ready/valid consumer.
module systolic_drain #(
    parameter int COLS  = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    systolic_drain_if.slave  bus
);
    localparam int DATA_W = 8;
    localparam int W      = COLS * DATA_W;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]    row_aligned;
    logic [COLS-2:0] vld_p;
    logic            row_done;

    // Stage p*: valid delay line, COLS-1 deep, marks the cycle a row is fully aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= bus.y_vld;
            for (int i = 1; i < COLS-1; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign row_done = vld_p[COLS-2];

    // Column c arrives c cycles after column 0, so it needs COLS-1-c cycles of delay.
    for (genvar c = 0; c < COLS-1; c++) begin : g_skew
        localparam int L = COLS - 1 - c;
        logic [DATA_W-1:0] col_p [L];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < L; i++) begin
                    col_p[i] <= '0;
                end
            end else begin
                col_p[0] <= bus.y_col[c*DATA_W +: DATA_W];
                for (int i = 1; i < L; i++) begin
                    col_p[i] <= col_p[i-1];
                end
            end
        end

        assign row_aligned[c*DATA_W +: DATA_W] = col_p[L-1];
    end

    assign row_aligned[(COLS-1)*DATA_W +: DATA_W] = bus.y_col[(COLS-1)*DATA_W +: DATA_W];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [7:0]    row_cnt_q;
    logic          ovf_q;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

    // A full FIFO still takes a row when the head leaves in the same cycle.
    assign full   = (cnt == DEPTH_CNT);
    assign pop    = (cnt != '0) && bus.out_ready;
    assign accept = row_done && (!full || pop);
    assign drop   = row_done && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= row_aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            row_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr    <= wr_ptr + AW'(1);
                row_cnt_q <= row_cnt_q + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (pop && !accept) begin
                cnt <= cnt - (AW+1)'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // The head is forced to zero when empty so stale storage never shows on the bus.
    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.fifo_cnt  = cnt;
    assign bus.row_cnt   = row_cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain: directed scenarios plus randomized
// traffic compared against a history-based row/queue reference model.
module tb_systolic_drain;
    localparam int COLS  = 4;
    localparam int DEPTH = 4;
    localparam int W     = COLS * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_drain_if #(.COLS(COLS), .DEPTH(DEPTH)) dif ();

    systolic_drain #(.COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: input history plus a queue of whole rows.
    int           cyc      = 0;
    int           last_rst = -100;
    logic         hist_vld [64];
    logic [W-1:0] hist_col [64];
    logic [W-1:0] q [$];
    logic [7:0]   m_rc  = '0;
    logic         m_ovf = 1'b0;

    // Directed stimulus plan: a row starting at cycle k, column c shown at k+c.
    logic         plan_vld [32];
    logic [W-1:0] plan_row [32];

    task automatic tick();
        int           k;
        int           t;
        logic         push;
        logic         drop;
        logic [W-1:0] row;
        k = cyc;
        hist_vld[k % 64] = dif.y_vld;
        hist_col[k % 64] = dif.y_col;
        if (rst) begin
            q.delete();
            m_rc     = '0;
            m_ovf    = 1'b0;
            last_rst = k;
        end else begin
            push = 1'b0;
            drop = 1'b0;
            row  = '0;
            t    = k - (COLS - 1);
            if (t >= 0 && t > last_rst && hist_vld[t % 64]) begin
                push = 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    row[c*8 +: 8] = hist_col[(t + c) % 64][c*8 +: 8];
                end
            end
            if (q.size() > 0 && dif.out_ready) begin
                void'(q.pop_front());
            end
            if (push) begin
                if (q.size() < DEPTH) begin
                    q.push_back(row);
                    m_rc = m_rc + 8'd1;
                end else begin
                    drop  = 1'b1;
                    m_ovf = 1'b1;
                end
            end
            if (!drop && dif.clr_ovf) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 32; i++) begin
            plan_vld[i] = 1'b0;
            plan_row[i] = '0;
        end
    endtask

    task automatic drive(input int k, input logic rdy, input logic clr);
        logic [W-1:0] col;
        int           idx;
        dif.y_vld = (k >= 0 && k < 32) ? plan_vld[k] : 1'b0;
        for (int c = 0; c < COLS; c++) begin
            idx = k - c;
            if (idx >= 0 && idx < 32 && plan_vld[idx]) col[c*8 +: 8] = plan_row[idx][c*8 +: 8];
            else col[c*8 +: 8] = 8'($urandom);
        end
        dif.y_col     = col;
        dif.out_ready = rdy;
        dif.clr_ovf   = clr;
    endtask

    task automatic apply_reset();
        clear_plan();
        rst = 1'b1;
        drive(-10, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dif.y_vld     = 1'b1;
            dif.y_col     = W'($urandom);
            dif.out_ready = 1'b1;
            dif.clr_ovf   = 1'b0;
            tick();
            n_cmp++;
            if ({dif.out_valid, dif.out_data, dif.ovf, dif.row_cnt, dif.fifo_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got valid=%b data=%h ovf=%b rc=%0d fc=%0d, required all zero",
                         dif.out_valid, dif.out_data, dif.ovf, dif.row_cnt, dif.fifo_cnt);
            end
        end
        rst = 1'b0;
        clear_plan();
        for (int i = 0; i < 8; i++) begin
            drive(-10, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (dif.out_valid !== 1'b0 || dif.fifo_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_vld_ignored: got valid=%b fc=%0d, required 0/0", dif.out_valid, dif.fifo_cnt);
            end
        end
    endtask

    task automatic test_single_row();
        apply_reset();
        plan_vld[0] = 1'b1;
        plan_row[0] = 32'h1312_1110;
        for (int j = 0; j < 12; j++) begin
            drive(j, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (dif.out_valid !== (j + 1 == 4)) begin
                n_fail++;
                $display("FAIL single_valid cyc%0d: got %b required %b", j + 1, dif.out_valid, (j + 1 == 4));
            end
            if (j + 1 == 4) begin
                n_cmp++;
                if (dif.out_data !== 32'h1312_1110 || dif.row_cnt !== 8'd1) begin
                    n_fail++;
                    $display("FAIL single_data: got data=%h rc=%0d required 13121110/1", dif.out_data, dif.row_cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            plan_vld[i] = 1'b1;
            plan_row[i] = W'($urandom);
        end
        for (int j = 0; j < 12; j++) begin
            drive(j, 1'b1, 1'b0);
            tick();
            c = j + 1;
            n_cmp++;
            if (dif.out_valid !== (c >= 4 && c <= 7)) begin
                n_fail++;
                $display("FAIL b2b_valid cyc%0d: got %b required %b", c, dif.out_valid, (c >= 4 && c <= 7));
            end
            if (c >= 4 && c <= 7) begin
                n_cmp++;
                if (dif.out_data !== plan_row[c - 4]) begin
                    n_fail++;
                    $display("FAIL b2b_data cyc%0d: got %h required %h", c, dif.out_data, plan_row[c - 4]);
                end
            end
            n_cmp++;
            if (dif.fifo_cnt > 1) begin
                n_fail++;
                $display("FAIL b2b_fifo_cnt cyc%0d: got %0d required <=1", c, dif.fifo_cnt);
            end
        end
    endtask

    task automatic drain_expect(input string name, input int first, input int last);
        int nxt;
        nxt = first;
        for (int j = 20; j < 32; j++) begin
            drive(j, 1'b1, 1'b0);
            if (dif.out_valid) begin
                n_cmp++;
                if (nxt > last) begin
                    n_fail++;
                    $display("FAIL %s_extra_row: got %h required no row", name, dif.out_data);
                end else if (dif.out_data !== plan_row[nxt]) begin
                    n_fail++;
                    $display("FAIL %s_order row%0d: got %h required %h", name, nxt, dif.out_data, plan_row[nxt]);
                end
                nxt++;
            end
            tick();
        end
        n_cmp++;
        if (nxt != last + 1) begin
            n_fail++;
            $display("FAIL %s_drain_count: got %0d rows required %0d", name, nxt - first, last - first + 1);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            plan_vld[i] = 1'b1;
            plan_row[i] = W'($urandom);
        end
        for (int j = 0; j < 10; j++) begin
            drive(j, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (dif.fifo_cnt !== 3'd4 || dif.ovf !== 1'b1 || dif.row_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL ovf_state: got fc=%0d ovf=%b rc=%0d required 4/1/4", dif.fifo_cnt, dif.ovf, dif.row_cnt);
        end
        drain_expect("ovf", 0, 3);
    endtask

    task automatic test_full_pop();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            plan_vld[i] = 1'b1;
            plan_row[i] = W'($urandom);
        end
        for (int j = 0; j < 10; j++) begin
            drive(j, (j == 7), 1'b0);
            tick();
        end
        n_cmp++;
        if (dif.fifo_cnt !== 3'd4 || dif.ovf !== 1'b0 || dif.row_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL fullpop_state: got fc=%0d ovf=%b rc=%0d required 4/0/5", dif.fifo_cnt, dif.ovf, dif.row_cnt);
        end
        drain_expect("fullpop", 1, 4);
    endtask

    task automatic test_reset_mid_row();
        apply_reset();
        plan_vld[0] = 1'b1;
        plan_row[0] = W'($urandom);
        for (int j = 0; j < 12; j++) begin
            rst = (j == 2);
            drive(j, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (dif.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_valid cyc%0d: got %b required 0", j + 1, dif.out_valid);
            end
        end
        rst = 1'b0;
        n_cmp++;
        if ({dif.out_data, dif.ovf, dif.row_cnt, dif.fifo_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got data=%h ovf=%b rc=%0d fc=%0d required all zero",
                     dif.out_data, dif.ovf, dif.row_cnt, dif.fifo_cnt);
        end
    endtask

    task automatic test_ovf_clear();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            plan_vld[i] = 1'b1;
            plan_row[i] = W'($urandom);
        end
        for (int j = 0; j < 10; j++) begin
            drive(j, 1'b0, (j == 7 || j == 8));
            tick();
            if (j == 6 || j == 7 || j == 8) begin
                n_cmp++;
                if (dif.ovf !== (j == 7)) begin
                    n_fail++;
                    $display("FAIL ovf_clear cyc%0d: got %b required %b", j + 1, dif.ovf, (j == 7));
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int j = 0; j < 600; j++) begin
            rst           = ($urandom_range(0, 149) == 0);
            dif.y_vld     = ($urandom_range(0, 2) != 0);
            dif.y_col     = W'($urandom);
            dif.out_ready = ((j / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            dif.clr_ovf   = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++;
            if (dif.out_valid !== (q.size() > 0) || dif.fifo_cnt !== 3'(q.size()) ||
                dif.row_cnt !== m_rc || dif.ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc%0d: got v=%b fc=%0d rc=%0d ovf=%b required v=%b fc=%0d rc=%0d ovf=%b",
                         cyc, dif.out_valid, dif.fifo_cnt, dif.row_cnt, dif.ovf,
                         (q.size() > 0), q.size(), m_rc, m_ovf);
            end
            if (q.size() > 0) begin
                n_cmp++;
                if (dif.out_data !== q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data cyc%0d: got %h required %h", cyc, dif.out_data, q[0]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        clear_plan();
        for (int i = 0; i < 64; i++) begin
            hist_vld[i] = 1'b0;
            hist_col[i] = '0;
        end
        dif.y_vld     = 1'b0;
        dif.y_col     = '0;
        dif.out_ready = 1'b0;
        dif.clr_ovf   = 1'b0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_row();
        test_ovf_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter COLS, default 4, number of PE columns drained.
REQ-002 Parameter DEPTH, default 4, result-row FIFO depth in entries (power of 2, >=2).
REQ-003 Ports: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Ports: rst, input, 1, synchronous active-high reset.
REQ-005 Ports: y_col, input, COLS*8, PE bottom-row y_out values; column c on bits [8c+7:8c].
REQ-006 Ports: y_vld, input, 1, column-0 value valid this cycle; column c value of the same row valid c cycles later.
REQ-007 Ports: out_data, output, COLS*8, deskewed result row, column c on bits [8c+7:8c].
REQ-008 Ports: out_valid, output, 1, out_data holds a row.
REQ-009 Ports: out_ready, input, 1, consumer accepts the row when out_valid && out_ready.
REQ-010 Ports: clr_ovf, input, 1, clears ovf.
REQ-011 Ports: ovf, output, 1, sticky flag: a completed row was dropped.
REQ-012 Ports: row_cnt, output, 8, rows accepted into the FIFO, mod 256.
REQ-013 Ports: fifo_cnt, output, clog2(DEPTH)+1, current FIFO occupancy.

Function
REQ-014 Deskew: y_vld high at cycle t defines one row; column c is sampled from y_col at cycle t+c.
REQ-015 Column c sample is delayed COLS-1-c cycles, so all columns align at cycle t+COLS-1.
REQ-016 y_vld is delayed COLS-1 cycles to form row_done; y_vld may be high on consecutive cycles, giving one row per cycle with no bubbles.
REQ-017 Push: row_done at cycle t+COLS-1 writes the aligned row into the FIFO at the end of that cycle.
REQ-018 Latency: with the FIFO empty, out_valid rises at cycle t+COLS.
REQ-019 out_data is the head entry and stays stable while out_valid && !out_ready.
REQ-020 Pop: out_valid && out_ready removes the head at the clock edge.
REQ-021 Ordering: rows leave in push order (FIFO); read/write pointers wrap modulo DEPTH.
REQ-022 Full: push with fifo_cnt==DEPTH and no pop drops the row, sets ovf, leaves FIFO and row_cnt unchanged.
REQ-023 Push on a full FIFO with a same-cycle pop is accepted; fifo_cnt stays DEPTH.
REQ-024 Empty: out_valid=0 when fifo_cnt==0; out_ready is ignored.
REQ-025 Push on an empty FIFO with out_ready high: no pop occurs that cycle; out_valid rises next cycle.
REQ-026 Push+pop with 0<fifo_cnt<DEPTH: fifo_cnt unchanged.
REQ-027 row_cnt increments by 1 per accepted push and wraps 255->0.
REQ-028 ovf: set by a drop, cleared by clr_ovf; if both occur in one cycle, set wins.
REQ-029 Data is 8-bit unsigned, passed through unmodified; no arithmetic on y_col.

Reset
REQ-030 rst high at a clock edge clears the deskew pipeline (data and valids), FIFO pointers, fifo_cnt, row_cnt and ovf.
REQ-031 During and after reset: out_valid=0, out_data=0, ovf=0, row_cnt=0, fifo_cnt=0.
REQ-032 Rows partially deskewed when rst asserts are discarded; none reach the FIFO after reset.
REQ-033 y_vld sampled in the same cycle as rst is ignored.

Verification (COLS=4, DEPTH=4)
REQ-034 Single row: y_vld at cycle 10, y_col column c = 0x10+c at cycle 10+c, out_ready=1 -> out_valid only at cycle 14, out_data=0x13121110, row_cnt=1.
REQ-035 Back-to-back: y_vld at cycles 10-13 with distinct rows -> out_valid at cycles 14-17, rows in order, fifo_cnt never exceeds 1.
REQ-036 Overflow: out_ready=0, then 5 rows back-to-back -> fifo_cnt=4, ovf=1, row_cnt=4; draining then yields rows 1-4, and row 5 is lost.
REQ-037 Full with pop: FIFO full, out_ready=1 in the cycle a 5th row pushes -> ovf stays 0, fifo_cnt stays 4, row_cnt=5.
REQ-038 Reset mid-row: y_vld at cycle 10, rst at cycle 12 -> no out_valid through cycle 20; all outputs 0.
REQ-039 ovf clear race: clr_ovf=1 in the same cycle as a drop -> ovf=1; clr_ovf alone the next cycle -> ovf=0.
